// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Operands are registered into the ALU; result and flags are captured one cycle later and returned with the requester id.
module alu_arbiter #(
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [P-1:0] req0_a,
    input  logic [P-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [P-1:0] req1_a,
    input  logic [P-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic [P-1:0] alu_a,
    output logic [P-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [P-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [P-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e       state_q;
    logic         last_grant_q;
    logic         id_q;
    logic         rsp_valid_q;
    logic         busy_q;
    logic [P-1:0] alu_a_q;
    logic [P-1:0] alu_b_q;
    logic [2:0]   alu_op_q;
    logic [P-1:0] rsp_result_q;
    logic [3:0]   rsp_flags_q;

    logic         grant0_d;
    logic         grant1_d;
    logic         accept_d;

    // Grant selection: under contention the requester not served last wins.
    always_comb begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0_d = last_grant_q;
            grant1_d = ~last_grant_q;
        end else begin
            grant0_d = req0_valid;
            grant1_d = req1_valid;
        end
        accept_d = (state_q == IDLE) && !rst && (grant0_d || grant1_d);
    end

    assign req0_ready = (state_q == IDLE) & ~rst & grant0_d;
    assign req1_ready = (state_q == IDLE) & ~rst & grant1_d;

    // Sequencer: accept into the ALU registers, capture the ALU output, hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 3'd0;
            rsp_result_q <= '0;
            rsp_flags_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        alu_a_q      <= grant1_d ? req1_a  : req0_a;
                        alu_b_q      <= grant1_d ? req1_b  : req0_b;
                        alu_op_q     <= grant1_d ? req1_op : req0_op;
                        id_q         <= grant1_d;
                        last_grant_q <= grant1_d;
                        busy_q       <= 1'b1;
                        state_q      <= EXEC;
                    end else begin
                        state_q      <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_flags_q  <= alu_flags;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    // The reset cycle itself must already look quiet.
    assign rsp_valid  = rsp_valid_q & ~rst;
    assign busy       = busy_q & ~rst;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural 4-bit ALU attached.
module tb_alu_arbiter;
    localparam int P = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, v0, v1, rsp_ready;
    logic [3:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;
    logic req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [3:0] alu_a, alu_b, alu_result, alu_flags, rsp_result, rsp_flags;
    logic [2:0] alu_op;

    int   n_vec = 0;
    int   n_err = 0;
    logic m_last;

    alu_arbiter #(.P(P)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(req0_ready), .req0_a(a0), .req0_b(b0), .req0_op(op0),
        .req1_valid(v1), .req1_ready(req1_ready), .req1_a(a1), .req1_b(b1), .req1_op(op1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    // Team ALU: returns {N,Z,C,V, result}
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [4:0] w;
        logic [3:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[3:0]; c = w[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
            3'd1: begin r = a - b; c = (a >= b); v = (a[3] != b[3]) && (r[3] != a[3]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = a << 1; c = a[3]; end
            3'd6: begin r = a >> 1; c = a[0]; end
            default: r = ~a;
        endcase
        return {r[3], (r == 4'd0), c, v, r};
    endfunction

    assign {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_op);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand0;
        a0 = 4'($urandom_range(0, 15)); b0 = 4'($urandom_range(0, 15)); op0 = 3'($urandom_range(0, 7));
    endtask

    task automatic rand1;
        a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15)); op1 = 3'($urandom_range(0, 7));
    endtask

    task automatic test_reset;
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rsp_ready = 1'b0;
        rand0(); rand1();
        repeat (2) begin
            @(negedge clk);
            n_vec++;
            if ({req0_ready, req1_ready, rsp_valid, busy} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_outputs got %b want 0000", {req0_ready, req1_ready, rsp_valid, busy});
            end
        end
        tick();
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; m_last = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({alu_a, alu_b, alu_op, rsp_result, rsp_flags, rsp_id, busy} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_values got %h want 0", {alu_a, alu_b, alu_op, rsp_result, rsp_flags, rsp_id, busy});
        end
        tick();
    endtask

    task automatic test_single(input logic who, input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] op, input logic [3:0] er, input logic [3:0] ef);
        rsp_ready = 1'b1;
        if (who) begin v1 = 1'b1; a1 = a; b1 = b; op1 = op; end
        else     begin v0 = 1'b1; a0 = a; b0 = b; op0 = op; end
        @(negedge clk);
        n_vec++;
        if ({req1_ready, req0_ready} !== (who ? 2'b10 : 2'b01)) begin
            n_err++;
            $display("FAIL single_ready got %b want id %0d", {req1_ready, req0_ready}, who);
        end
        tick();
        v0 = 1'b0; v1 = 1'b0; m_last = who;
        @(negedge clk);
        n_vec++;
        if ({alu_a, alu_b, alu_op, busy, rsp_valid} !== {a, b, op, 2'b10}) begin
            n_err++;
            $display("FAIL single_exec got %h want %h", {alu_a, alu_b, alu_op, busy, rsp_valid}, {a, b, op, 2'b10});
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_flags, rsp_result} !== {1'b1, who, ef, er}) begin
            n_err++;
            $display("FAIL single_rsp got %b want %b", {rsp_valid, rsp_id, rsp_flags, rsp_result}, {1'b1, who, ef, er});
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({busy, rsp_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL single_idle got %b want 00", {busy, rsp_valid});
        end
        tick();
    endtask

    task automatic test_contention;
        int acc_cyc[$];
        logic acc_id[$];
        logic [8:0] rsps[$];
        logic r0, r1;
        v0 = 1'b1; a0 = 4'd6;  b0 = 4'd2;  op0 = 3'd1;
        v1 = 1'b1; a1 = 4'd12; b1 = 4'd10; op1 = 3'd2;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && rsps.size() < 2; cyc++) begin
            @(negedge clk);
            if (rsp_valid) rsps.push_back({rsp_id, rsp_flags, rsp_result});
            r0 = req0_ready; r1 = req1_ready;
            if (r0 || r1) begin acc_cyc.push_back(cyc); acc_id.push_back(r1); end
            tick();
            if (r0) v0 = 1'b0;
            if (r1) v1 = 1'b0;
        end
        m_last = 1'b1;
        n_vec++;
        if (rsps.size() != 2 || acc_cyc.size() != 2) begin
            n_err++;
            $display("FAIL contention_timeout got %0d rsps %0d accepts want 2 2", rsps.size(), acc_cyc.size());
        end else begin
            n_vec += 3;
            if (rsps[0] !== {1'b0, 4'b0010, 4'd4}) begin
                n_err++; $display("FAIL contention_first got %b want %b", rsps[0], {1'b0, 4'b0010, 4'd4});
            end
            if (rsps[1] !== {1'b1, 4'b1000, 4'd8}) begin
                n_err++; $display("FAIL contention_second got %b want %b", rsps[1], {1'b1, 4'b1000, 4'd8});
            end
            if (acc_cyc[1] - acc_cyc[0] != 3 || acc_id[0] !== 1'b0) begin
                n_err++; $display("FAIL contention_spacing got %0d first_id %0d want 3 0", acc_cyc[1] - acc_cyc[0], acc_id[0]);
            end
        end
    endtask

    task automatic test_fairness;
        logic [8:0] expq[$];
        int nresp, last_acc;
        logic r0, r1;
        nresp = 0; last_acc = -1;
        v0 = 1'b1; v1 = 1'b1; rand0(); rand1(); rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && nresp < 6; cyc++) begin
            @(negedge clk);
            r0 = req0_ready; r1 = req1_ready;
            if (rsp_valid) begin
                nresp++;
                n_vec++;
                if (expq.size() == 0 || {rsp_id, rsp_flags, rsp_result} !== expq[0]) begin
                    n_err++;
                    $display("FAIL fairness_rsp got %b want %b", {rsp_id, rsp_flags, rsp_result}, (expq.size() != 0) ? expq[0] : 9'h1ff);
                end
                if (expq.size() != 0) void'(expq.pop_front());
            end
            if (r0 || r1) begin
                n_vec++;
                if ({r1, r0} !== (m_last ? 2'b01 : 2'b10) || (last_acc >= 0 && cyc - last_acc != 3)) begin
                    n_err++;
                    $display("FAIL fairness_grant got %b spacing %0d want id %0d spacing 3", {r1, r0}, cyc - last_acc, ~m_last);
                end
                expq.push_back(r1 ? {1'b1, alu_fn(a1, b1, op1)} : {1'b0, alu_fn(a0, b0, op0)});
                m_last = r1;
                last_acc = cyc;
            end
            tick();
            if (r0) rand0();
            if (r1) rand1();
        end
        v0 = 1'b0; v1 = 1'b0;
        n_vec++;
        if (nresp != 6) begin
            n_err++; $display("FAIL fairness_timeout got %0d want 6", nresp);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp;
        logic seen;
        seen = 1'b0;
        v0 = 1'b1; rand0(); rsp_ready = 1'b0;
        exp = alu_fn(a0, b0, op0);
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            seen = rsp_valid;
            if (req0_ready) m_last = 1'b0;
            tick();
            v0 = 1'b0;
        end
        n_vec++;
        if (!seen) begin
            n_err++; $display("FAIL backpressure_timeout got 0 want rsp_valid");
        end
        v0 = 1'b1; v1 = 1'b1; rand0(); rand1();
        repeat (5) begin
            @(negedge clk);
            n_vec++;
            if ({rsp_valid, rsp_id, rsp_flags, rsp_result, req0_ready, req1_ready, busy} !== {1'b1, 1'b0, exp, 3'b001}) begin
                n_err++;
                $display("FAIL backpressure_hold got %b want %b", {rsp_valid, rsp_id, rsp_flags, rsp_result, req0_ready, req1_ready, busy}, {1'b1, 1'b0, exp, 3'b001});
            end
            tick();
        end
        v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        n_vec++;
        if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b0000) begin
            n_err++; $display("FAIL backpressure_release got %b want 0000", {busy, rsp_valid, req0_ready, req1_ready});
        end
        tick();
    endtask

    task automatic test_reset_midop;
        logic [7:0] exp;
        v1 = 1'b1; rand1(); rsp_ready = 1'b1;
        tick();
        v1 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b0000) begin
            n_err++; $display("FAIL midop_rst_cycle got %b want 0000", {rsp_valid, busy, req0_ready, req1_ready});
        end
        tick();
        rst = 1'b0; m_last = 1'b1;
        v0 = 1'b1; v1 = 1'b1; rand0(); rand1();
        exp = alu_fn(a0, b0, op0);
        @(negedge clk);
        n_vec++;
        if ({alu_a, alu_b, alu_op, rsp_result, rsp_flags, rsp_id, busy, rsp_valid, req0_ready, req1_ready} !== {22'd0, 2'b10}) begin
            n_err++;
            $display("FAIL midop_after_reset got %h want %h", {alu_a, alu_b, alu_op, rsp_result, rsp_flags, rsp_id, busy, rsp_valid, req0_ready, req1_ready}, {22'd0, 2'b10});
        end
        tick();
        v0 = 1'b0; v1 = 1'b0; m_last = 1'b0;
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL midop_stale_rsp got %b want 0", rsp_valid);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_flags, rsp_result} !== {1'b1, 1'b0, exp}) begin
            n_err++; $display("FAIL midop_new_rsp got %b want %b", {rsp_valid, rsp_id, rsp_flags, rsp_result}, {1'b1, 1'b0, exp});
        end
        tick();
    endtask

    task automatic test_random(input int n);
        int phase, g, acc;
        logic [8:0] exp;
        phase = 0; acc = -1; exp = 9'd0;
        for (int cyc = 0; cyc < n; cyc++) begin
            if (acc == 0) v0 = 1'b0;
            if (acc == 1) v1 = 1'b0;
            if (!v0) begin if ($urandom_range(0, 1) == 1) begin v0 = 1'b1; rand0(); end end
            else if ($urandom_range(0, 19) == 0) v0 = 1'b0;
            if (!v1) begin if ($urandom_range(0, 1) == 1) begin v1 = 1'b1; rand1(); end end
            else if ($urandom_range(0, 19) == 0) v1 = 1'b0;
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = -1; acc = -1;
            if (phase == 0) begin
                if (v0 && v1) g = m_last ? 0 : 1;
                else if (v0) g = 0;
                else if (v1) g = 1;
            end
            n_vec++;
            if ({req0_ready, req1_ready, busy, rsp_valid} !== {g == 0, g == 1, phase != 0, phase == 2}) begin
                n_err++;
                $display("FAIL random_ctrl cyc %0d got %b want %b", cyc, {req0_ready, req1_ready, busy, rsp_valid}, {g == 0, g == 1, phase != 0, phase == 2});
            end
            if (phase == 2) begin
                n_vec++;
                if ({rsp_id, rsp_flags, rsp_result} !== exp) begin
                    n_err++; $display("FAIL random_rsp cyc %0d got %b want %b", cyc, {rsp_id, rsp_flags, rsp_result}, exp);
                end
            end
            case (phase)
                0: if (g >= 0) begin
                       exp = (g == 1) ? {1'b1, alu_fn(a1, b1, op1)} : {1'b0, alu_fn(a0, b0, op0)};
                       m_last = g[0]; acc = g; phase = 1;
                   end
                1: phase = 2;
                default: if (rsp_ready) phase = 0;
            endcase
            tick();
        end
        v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
        a0 = 4'd0; b0 = 4'd0; op0 = 3'd0; a1 = 4'd0; b1 = 4'd0; op1 = 3'd0;
        m_last = 1'b1;
        test_reset();
        test_single(1'b0, 4'd3, 4'd5, 3'd0, 4'd8, 4'b1001);
        test_single(1'b1, 4'd7, 4'd9, 3'd0, 4'd0, 4'b0110);
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_midop();
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational P-bit ALU between two requesters. Each requester hands over an operand pair and 3-bit opcode with a valid/ready handshake. The block drives the ALU from registered operands and captures result and flags one cycle later. It returns them on a single response channel tagged with the requester ID. It sits between the ALU and the two client blocks; the ALU itself is unchanged.

## Interface
- P, default 4, operand/result width, must match the ALU's P.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  P  requester 0 operands.
- req0_op  in  3  requester 0 opcode, forwarded unchanged to ALU.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- alu_a, alu_b  out  P  registered operands driving the ALU.
- alu_op  out  3  registered opcode driving the ALU OP select.
- alu_result  in  P  ALU Result.
- alu_flags  in  4  ALU flags packed {N,Z,C,V}.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the response's operation.
- rsp_result  out  P  captured result.
- rsp_flags  out  4  captured {N,Z,C,V}.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitrate between the two requesters.
  - If exactly one reqN_valid is high, grant it.
  - If both are high, grant the requester not granted last (last_grant register).
  - reqN_ready = (state==IDLE) & granted; it is combinational from both valids.
  - On handshake: latch reqN_a/b/op into alu_a/b/op, latch N into the id register, update last_grant, go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC: ALU output settles from the registered operands. At the clock edge, capture alu_result into rsp_result and alu_flags into rsp_flags, then go to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_id, rsp_result and rsp_flags stay stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE. No bypass to EXEC.
- Requesters hold a/b/op stable while valid and not yet ready. A request dropped before acceptance is never issued.
- Opcodes, including 3'b111, pass through without checking. Result and flags are whatever the ALU produces.
- alu_a/b/op hold their last value outside EXEC. They change only on an accept.
- Widths: no arithmetic in this block. Result and flags are copied bit-exact.
- Reset values:
  - state = IDLE; last_grant = 1, so req0 wins the first contention.
  - alu_a, alu_b, alu_op, rsp_result, rsp_flags and rsp_id all reset to 0.
  - rsp_valid = 0, busy = 0, req0_ready = req1_ready = 0 during the rst cycle.
- Reset mid-operation: any accepted but unreturned operation is dropped silently and no response is produced. The next request after reset follows the reset arbitration order.

## Timing
- Accept at edge t (handshake in cycle t-1→t): EXEC during cycle t, capture at edge t+1, rsp_valid high from cycle t+1.
- Latency from accepting handshake to rsp_valid: 2 cycles.
- Minimum spacing between accepts: 3 cycles, achieved when rsp_ready is held high.
- Backpressure: rsp_ready low holds RESP indefinitely. Both req_ready stay low meanwhile.
- Simultaneous valids under sustained load alternate strictly: 0,1,0,1…
- A requester whose valid is high in IDLE with no contention is granted in that same cycle.

## Test plan
Bench connects the team's ALU with P=4 and opcodes 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr.
- Reset then single request: req0 a=3, b=5, op=000 → req0_ready in cycle 0, rsp_valid at cycle 2, rsp_id=0, result=8, flags N=1,Z=0,C=0.
- Carry/zero check: req1 a=7, b=9, op=000 → rsp_id=1, result=0, Z=1, C=1.
- Contention: both valid, req0 a=6,b=2 op=001 and req1 a=12,b=10 op=010, rsp_ready=1 →
  - first response id=0, result=4;
  - second response id=1, result=8;
  - accepts 3 cycles apart.
- Round-robin fairness: both valid continuously for 6 operations → ids 0,1,0,1,0,1, with no starvation.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid → rsp fields stable, both req_ready 0, busy 1. rsp_ready=1 → back to IDLE next cycle.
- Reset mid-op: assert rst during EXEC → no rsp_valid afterwards, all outputs at reset values. Then both valid → req0 granted first.
